// File: rtl/sadd_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
// State encoding and default operand width.
package sadd_ctrl_pkg;

    localparam int W_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        FLUSH = ST_FLUSH,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/sadd_ctrl_ser_shreg.sv
// Width-parametrised shift register: sync load, shift right, serial-in at MSB.
// Load takes priority over shift.
module ser_shreg #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [N-1:0] i_d,
    input  logic         i_si,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_shift) begin
            r_q <= {i_si, r_q[N-1:1]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sadd_ctrl.sv
// Operand serializer and result collector for the bit-serial adder.
// Drives operands LSB-first, gathers z_i, one flush cycle recovers the carry.
module sadd_ctrl
    import sadd_ctrl_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W:0]   sum,
    output logic         x_o,
    output logic         y_o,
    output logic         add_rst_b,
    input  logic         z_i
);

    localparam int CW = $clog2(W);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [W:0]    r_sum;
    logic [W-1:0]  w_a;
    logic [W-1:0]  w_b;
    logic [W:0]    w_res;
    logic          w_load;
    logic          w_op_shift;
    logic          w_res_shift;
    logic          w_last;
    logic          w_unused;

    assign w_last = (r_cnt == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_op_shift  = 1'b0;
        w_res_shift = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        add_rst_b   = 1'b0;
        x_o         = 1'b0;
        y_o         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                busy        = 1'b1;
                add_rst_b   = 1'b1;
                x_o         = w_a[0];
                y_o         = w_b[0];
                w_op_shift  = 1'b1;
                w_res_shift = 1'b1;
                if (w_last) begin
                    w_next = FLUSH;
                end
            end
            FLUSH: begin
                busy        = 1'b1;
                add_rst_b   = 1'b1;
                w_res_shift = 1'b1;
                w_next      = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_load = 1'b1;
                    w_next = SHIFT;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
        end else if (w_op_shift) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // In FLUSH, z_i carries the final carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else if (r_state == FLUSH) begin
            r_sum <= {z_i, w_res[W:1]};
        end
    end

    assign sum = r_sum;

    ser_shreg #(.N(W)) u_a_sh (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_op_shift),
        .i_d     (a),
        .i_si    (1'b0),
        .o_q     (w_a)
    );

    ser_shreg #(.N(W)) u_b_sh (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_op_shift),
        .i_d     (b),
        .i_si    (1'b0),
        .o_q     (w_b)
    );

    ser_shreg #(.N(W + 1)) u_res_sh (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_res_shift),
        .i_d     ('0),
        .i_si    (z_i),
        .o_q     (w_res)
    );

    assign w_unused = ^{w_a[W-1:1], w_b[W-1:1], w_res[0]};

endmodule

// File: tb/tb_sadd_ctrl.sv
// Bench for sadd_ctrl paired with a behavioural bit-serial adder.
// Stimulus pushes expected sums; a monitor checks them on each done.
module tb_sadd_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W:0]   sum;
    logic         x_o;
    logic         y_o;
    logic         add_rst_b;
    logic         z;
    logic         r_c = 1'b0;

    always #5 clk = ~clk;

    sadd_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .x_o       (x_o),
        .y_o       (y_o),
        .add_rst_b (add_rst_b),
        .z_i       (z)
    );

    // Mealy serial adder: carry cleared while rst_b is low
    assign z = x_o ^ y_o ^ r_c;
    always @(posedge clk) begin
        if (!add_rst_b) r_c <= 1'b0;
        else r_c <= (x_o & y_o) | (x_o & r_c) | (y_o & r_c);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W:0] s;
        int         c;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("done_cycle", cyc, e.c);
            end
        end
    end

    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("busy_timeout", 32'd1, 32'd0);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) q.push_back('{({1'b0, av} + {1'b0, bv}), cyc + W + 1});
    endtask

    task automatic ser_chk(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic fz);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("x_o", 32'(x_o), 32'(av[i]));
            chk("y_o", 32'(y_o), 32'(bv[i]));
            chk("add_rst_b_shift", 32'(add_rst_b), 32'd1);
        end
        @(negedge clk);
        chk("flush_x", 32'(x_o), 32'd0);
        chk("flush_busy", 32'(busy), 32'd1);
        chk("flush_z", 32'(z), 32'(fz));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           n;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_x", 32'(x_o), 32'd0);
        chk("rst_y", 32'(y_o), 32'd0);
        chk("rst_add_rst_b", 32'(add_rst_b), 32'd0);
        rst = 1'b0;

        op(8'h05, 8'h03, 1'b1);
        ser_chk(8'h05, 8'h03, 1'b0);

        op(8'hFF, 8'h01, 1'b1);
        ser_chk(8'hFF, 8'h01, 1'b1);

        op(8'hFF, 8'hFF, 1'b1);
        op(8'h10, 8'h20, 1'b1);

        op(8'h5A, 8'h33, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = (i % 2 == 0);
            a = 8'($urandom);
            b = 8'($urandom);
        end
        @(negedge clk);
        start = 1'b0;

        op(8'h77, 8'h11, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_add_rst_b", 32'(add_rst_b), 32'd0);
        rst = 1'b0;
        repeat (12) @(posedge clk);

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            op(ra, rb, 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
